// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: locks onto the slot-0 sync marker, rebuilds
// the four channel words and publishes each complete frame with a valid pulse.
module tdm_demux4 #(
  parameter int W        = 1,
  parameter int MISS_MAX = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_en,
  input  logic           sync,
  input  logic [1:0]     s,
  output logic [4*W-1:0] y,
  output logic           frame_vld,
  output logic [W-1:0]   ys,
  output logic           locked,
  output logic [1:0]     slot,
  output logic           sync_err
);

  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [MW-1:0] MISS_LIM = MW'(MISS_MAX);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t              state, state_nx;
  logic [2:0][W-1:0]   shadow, shadow_nx;
  logic [1:0]          slot_nx;
  logic [MW-1:0]       miss, miss_nx, miss_inc;
  logic [4*W-1:0]      y_nx;
  logic                vld_nx, err_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      shadow    <= '0;
      slot      <= '0;
      miss      <= '0;
      y         <= '0;
      frame_vld <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      shadow    <= shadow_nx;
      slot      <= slot_nx;
      miss      <= miss_nx;
      y         <= y_nx;
      frame_vld <= vld_nx;
      sync_err  <= err_nx;
    end
  end

  assign miss_inc = miss + 1'b1;

  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    slot_nx   = slot;
    miss_nx   = miss;
    y_nx      = y;
    vld_nx    = 1'b0;
    err_nx    = 1'b0;
    if (din_en) begin
      case (state)
        HUNT: begin
          if (sync) begin
            shadow_nx[0] = din;
            slot_nx      = 2'd1;
            miss_nx      = '0;
            state_nx     = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == 2'd0) begin
            if (sync) begin
              shadow_nx[0] = din;
              slot_nx      = 2'd1;
              miss_nx      = '0;
            end else begin
              // Flywheel through a missing marker until the miss budget runs out.
              err_nx = 1'b1;
              if (miss_inc == MISS_LIM) begin
                state_nx = HUNT;
                slot_nx  = 2'd0;
                miss_nx  = '0;
              end else begin
                miss_nx      = miss_inc;
                shadow_nx[0] = din;
                slot_nx      = 2'd1;
              end
            end
          end else if (sync) begin
            // Marker arrived early: restart the frame on this beat.
            err_nx       = 1'b1;
            shadow_nx[0] = din;
            slot_nx      = 2'd1;
            miss_nx      = '0;
          end else if (slot == 2'd3) begin
            y_nx    = {din, shadow[2], shadow[1], shadow[0]};
            vld_nx  = 1'b1;
            slot_nx = 2'd0;
          end else if (slot == 2'd1) begin
            shadow_nx[1] = din;
            slot_nx      = 2'd2;
          end else begin
            shadow_nx[2] = din;
            slot_nx      = 2'd3;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);
  assign ys     = y[s*W +: W];

endmodule
